usb_tx_crc_gen: RTL and testbench

Transmit-side CRC generator for the USB 2.0 packet path. Accepts a PID-first byte stream from the packet assembler and classifies the packet by its PID. Token packets have the CRC5 field written over the top of their last byte. Data packets get the inverted CRC16 appended. Handshake and special packets pass through unchanged. The output feeds the NRZI/bit-stuff serializer and is bit-exact with the receive-side CRC5/CRC16 checkers.

---
 rtl/usb_tx_crc_gen_if.sv | 12 +
 rtl/usb_tx_crc_gen.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_usb_tx_crc_gen.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_crc_gen_if.sv
// Byte-stream handshake bundle (valid/ready/data/last) used on both sides of
// the USB transmit CRC generator. The master drives the byte, the slave
// drives ready.
interface usb_tx_crc_gen_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/usb_tx_crc_gen.sv
// usb_tx_crc_gen: transmit-side CRC generator for the USB 2.0 packet path.
// Classifies each packet by its PID, writes CRC5 over the tail of token
// packets, appends the inverted CRC16 to data packets and passes handshake
// and special packets through. One output register stage feeds the
// NRZI/bit-stuff serializer.
module usb_tx_crc_gen #(
  parameter int MAX_PAYLOAD = 1024
) (
  input  logic             clk,
  input  logic             rst,
  usb_tx_crc_gen_if.slave  s_if,
  usb_tx_crc_gen_if.master m_if,
  output logic             busy,
  output logic             pid_err,
  output logic             len_err
);

  localparam int               CNT_W      = $clog2(MAX_PAYLOAD + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(MAX_PAYLOAD + 1);
  localparam logic [4:0]       CRC5_INIT  = 5'h1F;
  localparam logic [15:0]      CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    TOK1,
    TOK2,
    DROP,
    DATA,
    CRC_LO,
    CRC_HI,
    PASS
  } state_t;

  // CRC5 (x^5+x^2+1), MSB-aligned shift register; bits enter LSB-first.
  // Only the low nbits of the byte are consumed.
  function automatic logic [4:0] crc5_update(input logic [4:0] crc,
                                             input logic [7:0] bits,
                                             input int         nbits);
    logic [4:0] c;
    logic       fb;
    c  = crc;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) begin
        fb = c[4] ^ bits[i];
        c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      end
    end
    return c;
  endfunction

  // CRC16 (reflected 0x8005 = 0xA001), one full byte LSB-first per call.
  function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                               input logic [7:0]  bits);
    logic [15:0] c;
    logic        fb;
    c  = crc;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ bits[i];
      c  = (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
    end
    return c;
  endfunction

  // Second token byte: inverted CRC5 occupies [7:3] with the register MSB
  // landing on bit 3 (first CRC bit on the wire); [2:0] carry ENDP/ADDR.
  function automatic logic [7:0] tok_byte2(input logic [4:0] crc,
                                           input logic [2:0] low);
    logic [7:0] b;
    b[2:0] = low;
    for (int i = 0; i < 5; i++) begin
      b[3+i] = ~crc[4-i];
    end
    return b;
  endfunction

  state_t            state_q,   state_d;
  state_t            pid_class;
  logic [4:0]        crc5_q,    crc5_d;
  logic [4:0]        crc5_tok2;
  logic [15:0]       crc16_q,   crc16_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              m_valid_q, m_valid_d;
  logic [7:0]        m_data_q,  m_data_d;
  logic              m_last_q,  m_last_d;
  logic              busy_q,    busy_d;
  logic              pid_err_q, pid_err_d;
  logic              len_err_q, len_err_d;
  logic              out_free;
  logic              s_ready_c;
  logic              accept;
  logic              pid_ok;

  assign out_free = !m_valid_q || m_if.ready;
  assign accept   = s_if.valid && s_ready_c;
  assign pid_ok   = (s_if.data[7:4] == ~s_if.data[3:0]);

  // Upstream ready: streaming states need a free output slot, DROP swallows
  // bytes unconditionally, CRC tail states take nothing from upstream.
  always_comb begin
    s_ready_c = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE, TOK1, TOK2, DATA, PASS: s_ready_c = out_free;
        DROP:                         s_ready_c = 1'b1;
        default:                      s_ready_c = 1'b0;
      endcase
    end
  end

  // Next-state, CRC and output-register load logic.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    crc5_d    = crc5_q;
    crc16_d   = crc16_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q && !m_if.ready;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    pid_err_d = 1'b0;
    len_err_d = 1'b0;
    pid_class = PASS;
    crc5_tok2 = crc5_update(crc5_q, s_if.data, 3);

    // Packet ends once its last byte leaves; a PID accepted in the same
    // cycle re-asserts busy below.
    if (m_valid_q && m_if.ready && m_last_q) begin
      busy_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = s_if.data;
          m_last_d  = 1'b0;
          busy_d    = 1'b1;
          crc5_d    = CRC5_INIT;
          crc16_d   = CRC16_INIT;
          cnt_d     = '0;
          if (!pid_ok) begin
            pid_err_d = 1'b1;
            pid_class = PASS;
          end else if (s_if.data[1:0] == 2'b01) begin
            pid_class = TOK1;
          end else if (s_if.data[1:0] == 2'b11) begin
            pid_class = DATA;
          end else begin
            pid_class = PASS;
          end
          if (s_if.last) begin
            case (pid_class)
              DATA: state_d = CRC_LO;
              TOK1: begin
                len_err_d = 1'b1;
                m_last_d  = 1'b1;
                state_d   = IDLE;
              end
              default: begin
                m_last_d = 1'b1;
                state_d  = IDLE;
              end
            endcase
          end else begin
            state_d = pid_class;
          end
        end
      end

      TOK1: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = s_if.data;
          m_last_d  = s_if.last;
          crc5_d    = crc5_update(crc5_q, s_if.data, 8);
          if (s_if.last) begin
            len_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = TOK2;
          end
        end
      end

      TOK2: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = tok_byte2(crc5_tok2, s_if.data[2:0]);
          m_last_d  = 1'b1;
          crc5_d    = crc5_tok2;
          if (s_if.last) begin
            state_d = IDLE;
          end else begin
            len_err_d = 1'b1;
            state_d   = DROP;
          end
        end
      end

      DROP: begin
        if (accept && s_if.last) begin
          state_d = IDLE;
        end
      end

      DATA: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = s_if.data;
          m_last_d  = 1'b0;
          crc16_d   = crc16_update(crc16_q, s_if.data);
          // Saturating count so the oversize flag fires exactly once.
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_q == CNT_LIMIT) begin
            len_err_d = 1'b1;
          end
          if (s_if.last) begin
            state_d = CRC_LO;
          end
        end
      end

      CRC_LO: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = ~crc16_q[7:0];
          m_last_d  = 1'b0;
          state_d   = CRC_HI;
        end
      end

      CRC_HI: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = ~crc16_q[15:8];
          m_last_d  = 1'b1;
          state_d   = IDLE;
        end
      end

      PASS: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = s_if.data;
          m_last_d  = s_if.last;
          if (s_if.last) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, CRC, counter and output register; synchronous reset abandons
  // any packet in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      crc5_q    <= CRC5_INIT;
      crc16_q   <= CRC16_INIT;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      pid_err_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc5_q    <= crc5_d;
      crc16_q   <= crc16_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      pid_err_q <= pid_err_d;
      len_err_q <= len_err_d;
    end
  end

  assign s_if.ready = s_ready_c;
  assign m_if.valid = m_valid_q;
  assign m_if.data  = m_data_q;
  assign m_if.last  = m_last_q;
  assign busy       = busy_q;
  assign pid_err    = pid_err_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_usb_tx_crc_gen.sv
// Self-checking bench for usb_tx_crc_gen. A packet-level reference model
// (bit-serial reflected CRC5, table-driven CRC16) produces the expected
// output byte stream and error-pulse counts for every packet sent.
module tb_usb_tx_crc_gen;
  localparam int MAX_PAYLOAD = 1024;

  logic clk = 1'b0;
  logic rst;
  logic busy, pid_err, len_err;

  usb_tx_crc_gen_if s_if ();
  usb_tx_crc_gen_if m_if ();

  usb_tx_crc_gen #(.MAX_PAYLOAD(MAX_PAYLOAD)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_if    (s_if),
    .m_if    (m_if),
    .busy    (busy),
    .pid_err (pid_err),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [7:0]  tx_q[$];
  logic [8:0]  out_q[$];      // {last, data} of every downstream transfer
  int          out_cyc[$];
  logic [8:0]  exp_q[$];
  int          exp_pid_err, exp_len_err;
  int          pid_err_cnt  = 0;
  int          len_err_cnt  = 0;
  int          stall_viol   = 0;
  int          cycle        = 0;
  int          out_base, pid_base, len_base, viol_base;
  bit          rand_ready   = 1'b0;
  logic [15:0] crc16_tab [256];
  logic [8:0]  prev_out     = '0;
  bit          prev_stall   = 1'b0;

  // Downstream ready: always 1, or a fair coin when rand_ready is set.
  initial begin
    m_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor, sampled mid-cycle: logs transfers, counts error pulses and
  // watches that a stalled output holds still.
  always @(negedge clk) begin
    cycle++;
    if (prev_stall && (!m_if.valid || {m_if.last, m_if.data} !== prev_out)) stall_viol++;
    prev_stall = !rst && m_if.valid && !m_if.ready;
    prev_out   = {m_if.last, m_if.data};
    if (!rst && m_if.valid && m_if.ready) begin
      out_q.push_back({m_if.last, m_if.data});
      out_cyc.push_back(cycle);
    end
    if (pid_err === 1'b1) pid_err_cnt++;
    if (len_err === 1'b1) len_err_cnt++;
  end

  task automatic build_tab();
    logic [15:0] c;
    for (int v = 0; v < 256; v++) begin
      c = 16'(v);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      crc16_tab[v] = c;
    end
  endtask

  // Reflected CRC5 over the 11-bit token field; result bit0 lands on byte2[3].
  function automatic logic [7:0] ref_tok_byte2(input logic [7:0] b1, input logic [7:0] b2);
    logic [10:0] field;
    logic [4:0]  crc;
    field = {b2[2:0], b1};
    crc   = 5'h1F;
    for (int k = 0; k < 11; k++) crc = (crc[0] ^ field[k]) ? ((crc >> 1) ^ 5'h14) : (crc >> 1);
    return {~crc, b2[2:0]};
  endfunction

  // Appends the expected output of the packet in tx_q to exp_q.
  function automatic void model_append();
    int          n;
    logic [7:0]  pid;
    logic [15:0] crc;
    n   = tx_q.size();
    pid = tx_q[0];
    if (pid[7:4] != ~pid[3:0]) begin
      exp_pid_err++;
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), tx_q[i]});
    end else if (pid[1:0] == 2'b01) begin
      exp_q.push_back({(n == 1), pid});
      if (n == 1) exp_len_err++;
      else begin
        exp_q.push_back({(n == 2), tx_q[1]});
        if (n == 2) exp_len_err++;
        else begin
          exp_q.push_back({1'b1, ref_tok_byte2(tx_q[1], tx_q[2])});
          if (n > 3) exp_len_err++;
        end
      end
    end else if (pid[1:0] == 2'b11) begin
      crc = 16'hFFFF;
      exp_q.push_back({1'b0, pid});
      for (int i = 1; i < n; i++) begin
        exp_q.push_back({1'b0, tx_q[i]});
        crc = (crc >> 8) ^ crc16_tab[crc[7:0] ^ tx_q[i]];
      end
      exp_q.push_back({1'b0, ~crc[7:0]});
      exp_q.push_back({1'b1, ~crc[15:8]});
      if (n - 1 > MAX_PAYLOAD) exp_len_err++;
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), tx_q[i]});
    end
  endfunction

  task automatic start_pkt();
    out_base  = out_q.size();
    pid_base  = pid_err_cnt;
    len_base  = len_err_cnt;
    viol_base = stall_viol;
    exp_q.delete();
    exp_pid_err = 0;
    exp_len_err = 0;
  endtask

  // Drives tx_q upstream one byte per handshake; called at posedge+1.
  task automatic send_pkt(input bit mark_last);
    int guard;
    bit acc;
    for (int i = 0; i < tx_q.size(); i++) begin
      s_if.valid = 1'b1;
      s_if.data  = tx_q[i];
      s_if.last  = mark_last && (i == tx_q.size() - 1);
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 2000) begin
        @(negedge clk);
        acc = s_if.ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        tests_run++;
        tests_failed++;
        $display("FAIL send_timeout: byte %0d not accepted, got s_ready=0 want 1", i);
        break;
      end
    end
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int guard = 0;
    while (out_q.size() < out_base + exp_q.size() && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (out_q.size() < out_base + exp_q.size()) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: got %0d bytes want %0d", name, out_q.size() - out_base, exp_q.size());
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size() && out_base + i < out_q.size(); i++)
      if (out_q[out_base + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({m_if.valid, m_if.data, m_if.last} !== 10'h000) begin
      tests_failed++;
      $display("FAIL reset_out: got v=%b d=%h l=%b want 0 00 0", m_if.valid, m_if.data, m_if.last);
    end
    tests_run++;
    if ({busy, pid_err, len_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/pid/len=%b%b%b want 000", busy, pid_err, len_err);
    end
    tests_run++;
    if (s_if.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_s_ready: got %b want 0", s_if.ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (s_if.ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_s_ready: got %b want 1", s_if.ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_token_setup();
    int d;
    start_pkt();
    tx_q = '{8'h2D, 8'h00, 8'h00};
    exp_q = '{9'h02D, 9'h000, 9'h110};
    send_pkt(1'b1);
    wait_out("setup");
    d = first_diff();
    tests_run++;
    if (out_q.size() - out_base !== 3 || d !== -1) begin
      tests_failed++;
      $display("FAIL setup_bytes: got %0d bytes (diff at %0d) want 2D 00 10(last)", out_q.size() - out_base, d);
    end
  endtask

  task automatic test_token_random();
    logic [7:0] pids [4];
    int d;
    pids = '{8'hE1, 8'h69, 8'h2D, 8'hA5};
    for (int k = 0; k < 100; k++) begin
      rand_ready = k[0];
      start_pkt();
      tx_q = '{pids[$urandom_range(0, 3)], 8'($urandom), 8'($urandom)};
      model_append();
      send_pkt(1'b1);
      wait_out("tok_rand");
      d = first_diff();
      tests_run++;
      if (out_q.size() - out_base !== exp_q.size() || d !== -1) begin
        tests_failed++;
        $display("FAIL tok_rand[%0d]: %h %h %h got %0d bytes diff@%0d want %h", k, tx_q[0], tx_q[1], tx_q[2],
                 out_q.size() - out_base, d, exp_q[2]);
      end
    end
    rand_ready = 1'b0;
  endtask

  task automatic test_data_crc();
    int d;
    start_pkt();
    tx_q = '{8'hC3};
    exp_q = '{9'h0C3};
    for (int i = 0; i < 9; i++) begin
      tx_q.push_back(8'h31 + 8'(i));
      exp_q.push_back({1'b0, 8'h31 + 8'(i)});
    end
    exp_q.push_back(9'h0C8);
    exp_q.push_back(9'h1B4);
    send_pkt(1'b1);
    wait_out("data");
    d = first_diff();
    tests_run++;
    if (out_q.size() - out_base !== 12 || d !== -1) begin
      tests_failed++;
      $display("FAIL data_crc: got %0d bytes diff@%0d want C3 31..39 C8 B4(last)", out_q.size() - out_base, d);
    end
    if (out_q.size() - out_base == 12) begin
      tests_run++;
      if (out_cyc[out_base + 11] - out_cyc[out_base] !== 11) begin
        tests_failed++;
        $display("FAIL data_consecutive: got span %0d cycles want 11", out_cyc[out_base + 11] - out_cyc[out_base]);
      end
    end
  endtask

  task automatic test_zero_len_handshake();
    int d;
    start_pkt();
    tx_q = '{8'h4B};
    exp_q = '{9'h04B, 9'h000, 9'h100};
    send_pkt(1'b1);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_high: got %b want 1", busy);
    end
    wait_out("zlp");
    d = first_diff();
    tests_run++;
    if (out_q.size() - out_base !== 3 || d !== -1) begin
      tests_failed++;
      $display("FAIL zlp: got %0d bytes diff@%0d want 4B 00 00(last)", out_q.size() - out_base, d);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_low: got %b want 0", busy);
    end
    start_pkt();
    tx_q = '{8'hD2};
    exp_q = '{9'h1D2};
    send_pkt(1'b1);
    wait_out("ack");
    d = first_diff();
    tests_run++;
    if (out_q.size() - out_base !== 1 || d !== -1) begin
      tests_failed++;
      $display("FAIL ack: got %0d bytes diff@%0d want D2(last)", out_q.size() - out_base, d);
    end
  endtask

  task automatic test_backpressure();
    int d;
    rand_ready = 1'b1;
    start_pkt();
    tx_q = '{8'hC3};
    for (int i = 0; i < 9; i++) tx_q.push_back(8'h31 + 8'(i));
    model_append();
    send_pkt(1'b1);
    wait_out("bp");
    rand_ready = 1'b0;
    d = first_diff();
    tests_run++;
    if (out_q.size() - out_base !== exp_q.size() || d !== -1) begin
      tests_failed++;
      $display("FAIL bp_bytes: got %0d bytes diff@%0d want %0d", out_q.size() - out_base, d, exp_q.size());
    end
    tests_run++;
    if (stall_viol - viol_base !== 0) begin
      tests_failed++;
      $display("FAIL bp_stable: got %0d stall changes want 0", stall_viol - viol_base);
    end
  endtask

  task automatic test_errors();
    int d;
    for (int s = 0; s < 5; s++) begin
      start_pkt();
      case (s)
        0: tx_q = '{8'h35, 8'hAA};                      // bad check bits, token-coded
        1: tx_q = '{8'h3C};                             // 0x3C check bits agree: no pid_err
        2: tx_q = '{8'hE1, 8'h01, 8'h02, 8'h03, 8'h04}; // over-long token, tail dropped
        3: tx_q = '{8'hE1, 8'h01};                      // short token
        default: tx_q = '{8'h69};                       // bare token PID
      endcase
      model_append();
      send_pkt(1'b1);
      wait_out("err");
      d = first_diff();
      tests_run++;
      if (out_q.size() - out_base !== exp_q.size() || d !== -1) begin
        tests_failed++;
        $display("FAIL err_bytes[%0d]: got %0d bytes diff@%0d want %0d", s, out_q.size() - out_base, d, exp_q.size());
      end
      tests_run++;
      if (pid_err_cnt - pid_base !== exp_pid_err || len_err_cnt - len_base !== exp_len_err) begin
        tests_failed++;
        $display("FAIL err_pulses[%0d]: got pid=%0d len=%0d want pid=%0d len=%0d", s,
                 pid_err_cnt - pid_base, len_err_cnt - len_base, exp_pid_err, exp_len_err);
      end
    end
  endtask

  task automatic test_long_payload();
    int d;
    for (int len = MAX_PAYLOAD; len <= MAX_PAYLOAD + 1; len++) begin
      start_pkt();
      tx_q = '{8'hC3};
      for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
      model_append();
      send_pkt(1'b1);
      wait_out("long");
      d = first_diff();
      tests_run++;
      if (out_q.size() - out_base !== exp_q.size() || d !== -1) begin
        tests_failed++;
        $display("FAIL long_bytes[%0d]: got %0d bytes diff@%0d want %0d", len, out_q.size() - out_base, d, exp_q.size());
      end
      tests_run++;
      if (len_err_cnt - len_base !== exp_len_err) begin
        tests_failed++;
        $display("FAIL long_len_err[%0d]: got %0d want %0d", len, len_err_cnt - len_base, exp_len_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pids [12];
    int d, n;
    pids = '{8'hE1, 8'h69, 8'h2D, 8'hA5, 8'hC3, 8'h4B, 8'h87, 8'hD2, 8'h5A, 8'h1E, 8'h35, 8'h00};
    rand_ready = 1'b1;
    start_pkt();
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(1, 8);
      tx_q = '{pids[$urandom_range(0, 11)]};
      for (int i = 1; i < n; i++) tx_q.push_back(8'($urandom));
      model_append();
      send_pkt(1'b1);
    end
    wait_out("b2b");
    rand_ready = 1'b0;
    d = first_diff();
    tests_run++;
    if (out_q.size() - out_base !== exp_q.size() || d !== -1) begin
      tests_failed++;
      $display("FAIL b2b_bytes: got %0d bytes diff@%0d want %0d", out_q.size() - out_base, d, exp_q.size());
    end
    tests_run++;
    if (pid_err_cnt - pid_base !== exp_pid_err || len_err_cnt - len_base !== exp_len_err) begin
      tests_failed++;
      $display("FAIL b2b_pulses: got pid=%0d len=%0d want pid=%0d len=%0d",
               pid_err_cnt - pid_base, len_err_cnt - len_base, exp_pid_err, exp_len_err);
    end
  endtask

  task automatic test_reset_mid();
    int d;
    start_pkt();
    tx_q = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_pkt(1'b0);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (s_if.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_rst_s_ready: got %b want 0", s_if.ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tests_run++;
    if ({m_if.valid, m_if.data, m_if.last, busy, pid_err, len_err} !== 13'h0) begin
      tests_failed++;
      $display("FAIL mid_rst_out: got v=%b d=%h l=%b busy=%b pid=%b len=%b want all 0",
               m_if.valid, m_if.data, m_if.last, busy, pid_err, len_err);
    end
    start_pkt();
    tx_q = '{8'hD2};
    exp_q = '{9'h1D2};
    send_pkt(1'b1);
    wait_out("mid_ack");
    d = first_diff();
    tests_run++;
    if (out_q.size() - out_base !== 1 || d !== -1) begin
      tests_failed++;
      $display("FAIL mid_rst_ack: got %0d bytes diff@%0d want D2(last) alone", out_q.size() - out_base, d);
    end
  endtask

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = 8'h00;
    s_if.last  = 1'b0;
    build_tab();
    test_reset();
    test_token_setup();
    test_token_random();
    test_data_crc();
    test_zero_len_handshake();
    test_backpressure();
    test_errors();
    test_long_payload();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
